// File: rtl/adc_lane_aligner.sv
// Frame alignment and 2-lane sample assembly for multi-channel serial ADCs (CLKDIV domain).
// Drives bitslip until the frame word matches, holds lock, and re-trains when lock is lost.
module adc_lane_aligner #(
    parameter int               NUM_CH        = 3,
    parameter int               SER_W         = 8,
    parameter int               RES           = 14,
    parameter logic [SER_W-1:0] FRAME_PATTERN = 8'hF0,
    parameter int               SLIP_WAIT     = 4,
    parameter int               LOCK_COUNT    = 16,
    parameter int               MISS_LIMIT    = 4
) (
    input  logic                           CLKDIV,
    input  logic                           cpu_resetn,
    input  logic                           en,
    input  logic [SER_W-1:0]               fco_data,
    input  logic [NUM_CH*SER_W-1:0]        lane0_data,
    input  logic [NUM_CH*SER_W-1:0]        lane1_data,
    output logic                           bitslip,
    output logic                           locked,
    output logic                           align_err,
    output logic [$clog2(2*SER_W+1)-1:0]   slip_cnt,
    output logic [NUM_CH*RES-1:0]          sample_o,
    output logic                           sample_valid,
    output logic [15:0]                    frame_err_cnt
);

    localparam int SCW = $clog2(2*SER_W+1);
    localparam int WCW = $clog2(SLIP_WAIT+1);
    localparam int GCW = $clog2(LOCK_COUNT+1);
    localparam int MCW = $clog2(MISS_LIMIT+1);

    localparam logic [SCW-1:0] SLIP_MAX  = SCW'(2*SER_W);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(SLIP_WAIT-1);
    localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_COUNT-1);
    localparam logic [MCW-1:0] MISS_LAST = MCW'(MISS_LIMIT-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_SLIP,
        S_VERIFY,
        S_LOCKED,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic                  bitslip_q;
    logic                  locked_q;
    logic                  align_err_q;
    logic [SCW-1:0]        slip_cnt_q;
    logic [WCW-1:0]        wait_cnt_q;
    logic [GCW-1:0]        good_cnt_q;
    logic [MCW-1:0]        miss_cnt_q;
    logic [15:0]           frame_err_cnt_q;
    logic [NUM_CH*RES-1:0] sample_d;
    logic [NUM_CH*RES-1:0] sample_q;
    logic                  frame_ok;

    assign frame_ok = (fco_data == FRAME_PATTERN);

    always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q         <= S_IDLE;
            bitslip_q       <= 1'b0;
            locked_q        <= 1'b0;
            align_err_q     <= 1'b0;
            slip_cnt_q      <= '0;
            wait_cnt_q      <= '0;
            good_cnt_q      <= '0;
            miss_cnt_q      <= '0;
            frame_err_cnt_q <= '0;
        end else if (!en) begin
            state_q     <= S_IDLE;
            bitslip_q   <= 1'b0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
            slip_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            good_cnt_q  <= '0;
            miss_cnt_q  <= '0;
        end else begin
            bitslip_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                    slip_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) state_q <= S_CHECK;
                    else                         wait_cnt_q <= wait_cnt_q + WCW'(1);
                end
                // The pulse is raised on entry so bitslip is high for exactly the SLIP cycle.
                S_CHECK, S_VERIFY: begin
                    if (!frame_ok) begin
                        if (slip_cnt_q == SLIP_MAX) begin
                            state_q     <= S_ERROR;
                            align_err_q <= 1'b1;
                        end else begin
                            state_q    <= S_SLIP;
                            bitslip_q  <= 1'b1;
                            slip_cnt_q <= slip_cnt_q + SCW'(1);
                        end
                    end else if (state_q == S_CHECK) begin
                        good_cnt_q <= GCW'(1);
                        miss_cnt_q <= '0;
                        if (LOCK_COUNT <= 1) begin
                            state_q  <= S_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= S_VERIFY;
                        end
                    end else begin
                        good_cnt_q <= good_cnt_q + GCW'(1);
                        if (good_cnt_q == GOOD_LAST) begin
                            state_q  <= S_LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                S_SLIP: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= '0;
                end
                S_LOCKED: begin
                    if (frame_ok) begin
                        miss_cnt_q <= '0;
                    end else begin
                        if (frame_err_cnt_q != '1) frame_err_cnt_q <= frame_err_cnt_q + 16'd1;
                        if (miss_cnt_q == MISS_LAST) begin
                            state_q    <= S_WAIT;
                            locked_q   <= 1'b0;
                            slip_cnt_q <= '0;
                            wait_cnt_q <= '0;
                            miss_cnt_q <= '0;
                        end else begin
                            miss_cnt_q <= miss_cnt_q + MCW'(1);
                        end
                    end
                end
                S_ERROR: begin
                    align_err_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // MSB-first interleave: lane1 bit k -> RES-1-2k, lane0 bit k -> RES-2-2k.
    always_comb begin
        sample_d = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < RES/2; k++) begin
                sample_d[c*RES + RES-1-2*k] = lane1_data[c*SER_W + k];
                sample_d[c*RES + RES-2-2*k] = lane0_data[c*SER_W + k];
            end
        end
    end

    always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
        if (!cpu_resetn) sample_q <= '0;
        else             sample_q <= sample_d;
    end

    logic unused_lane_bits;
    assign unused_lane_bits = ^{lane0_data, lane1_data};

    assign bitslip       = bitslip_q;
    assign locked        = locked_q;
    assign align_err     = align_err_q;
    assign slip_cnt      = slip_cnt_q;
    assign sample_o      = sample_q;
    assign sample_valid  = locked_q;
    assign frame_err_cnt = frame_err_cnt_q;

endmodule

// File: tb/tb_adc_lane_aligner.sv
// Self-checking bench for adc_lane_aligner: reset, training, lock loss, sample assembly, async reset.
module tb_adc_lane_aligner;

    localparam int               NUM_CH     = 3;
    localparam int               SER_W      = 8;
    localparam int               RES        = 14;
    localparam logic [SER_W-1:0] FRAME      = 8'hF0;
    localparam int               SLIP_WAIT  = 4;
    localparam int               LOCK_COUNT = 16;
    localparam int               MISS_LIMIT = 4;

    logic                         CLKDIV;
    logic                         cpu_resetn;
    logic                         en;
    logic [SER_W-1:0]             fco_data;
    logic [NUM_CH*SER_W-1:0]      lane0_data;
    logic [NUM_CH*SER_W-1:0]      lane1_data;
    logic                         bitslip;
    logic                         locked;
    logic                         align_err;
    logic [$clog2(2*SER_W+1)-1:0] slip_cnt;
    logic [NUM_CH*RES-1:0]        sample_o;
    logic                         sample_valid;
    logic [15:0]                  frame_err_cnt;

    adc_lane_aligner #(
        .NUM_CH(NUM_CH), .SER_W(SER_W), .RES(RES), .FRAME_PATTERN(FRAME),
        .SLIP_WAIT(SLIP_WAIT), .LOCK_COUNT(LOCK_COUNT), .MISS_LIMIT(MISS_LIMIT)
    ) dut (
        .CLKDIV(CLKDIV), .cpu_resetn(cpu_resetn), .en(en), .fco_data(fco_data),
        .lane0_data(lane0_data), .lane1_data(lane1_data), .bitslip(bitslip),
        .locked(locked), .align_err(align_err), .slip_cnt(slip_cnt),
        .sample_o(sample_o), .sample_valid(sample_valid), .frame_err_cnt(frame_err_cnt)
    );

    initial CLKDIV = 1'b0;
    always #5 CLKDIV = ~CLKDIV;

    typedef struct {
        logic [7:0]  l1;
        logic [7:0]  l0;
        logic [13:0] exp;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    int         pulses, lock_at, last, width_bad, extra, err_at, run, idx;
    int         gaps [$];
    logic [15:0] err_m;
    logic       exp_lock, prev_bs, miss;
    logic [7:0] pl1 [NUM_CH];
    logic [7:0] pl0 [NUM_CH];
    logic [7:0] r1, r0, fv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bitslip"}, 64'(bitslip), 64'd0);
        check({tag, "_locked"}, 64'(locked), 64'd0);
        check({tag, "_align_err"}, 64'(align_err), 64'd0);
        check({tag, "_slip_cnt"}, 64'(slip_cnt), 64'd0);
        check({tag, "_sample_o"}, 64'(sample_o), 64'd0);
        check({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
        check({tag, "_frame_err_cnt"}, 64'(frame_err_cnt), 64'd0);
    endtask

    // Reference interleave from the bit-placement rule, using plain shifts and sums.
    function automatic int unsigned model_sample(input int unsigned l1, input int unsigned l0);
        int unsigned v;
        v = 0;
        for (int k = 0; k < RES/2; k++) begin
            v += ((l1 >> k) & 32'd1) << (RES-1-2*k);
            v += ((l0 >> k) & 32'd1) << (RES-2-2*k);
        end
        return v;
    endfunction

    initial begin
        vecs[0] = '{8'h00, 8'h01, 14'h1000};
        vecs[1] = '{8'h7F, 8'h00, 14'h2AAA};
        vecs[2] = '{8'h00, 8'h7F, 14'h1555};
        vecs[3] = '{8'hFF, 8'hFF, 14'h3FFF};
        vecs[4] = '{8'h80, 8'h80, 14'h0000};
        vecs[5] = '{8'h01, 8'h00, 14'h2000};
        vecs[6] = '{8'h40, 8'h00, 14'h0002};
        vecs[7] = '{8'h00, 8'h40, 14'h0001};
        vecs[8] = '{8'h0F, 8'hF0, 14'h2A95};

        cpu_resetn = 1'b0;
        en         = 1'b0;
        fco_data   = FRAME;
        lane0_data = '0;
        lane1_data = '0;
        repeat (2) @(negedge CLKDIV);
        check_all_zero("reset");
        cpu_resetn = 1'b1;
        @(negedge CLKDIV);

        // Aligned from the start: lock after SLIP_WAIT + 1 + LOCK_COUNT edges.
        en = 1'b1;
        lock_at = 0;
        pulses  = 0;
        for (int i = 1; i <= 60 && lock_at == 0; i++) begin
            @(negedge CLKDIV);
            if (bitslip) pulses++;
            if (locked) lock_at = i;
        end
        check("lock_latency", 64'(lock_at), 64'(SLIP_WAIT + 1 + LOCK_COUNT));
        check("aligned_no_slip", 64'(pulses), 64'd0);
        check("aligned_slip_cnt", 64'(slip_cnt), 64'd0);
        check("aligned_frame_err", 64'(frame_err_cnt), 64'd0);

        for (int i = 0; i < NV; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                idx = (i + c) % NV;
                lane1_data[c*SER_W +: SER_W] = vecs[idx].l1;
                lane0_data[c*SER_W +: SER_W] = vecs[idx].l0;
            end
            @(negedge CLKDIV);
            for (int c = 0; c < NUM_CH; c++) begin
                idx = (i + c) % NV;
                check("vec_sample", 64'(sample_o[c*RES +: RES]), 64'(vecs[idx].exp));
            end
            check("vec_valid", 64'(sample_valid), 64'd1);
        end

        // Three misses then a good frame keep lock; four in a row drop it.
        fco_data = 8'h0F; @(negedge CLKDIV); check("miss1_locked", 64'(locked), 64'd1);
        fco_data = 8'hF1; @(negedge CLKDIV); check("miss2_locked", 64'(locked), 64'd1);
        fco_data = 8'h70; @(negedge CLKDIV); check("miss3_locked", 64'(locked), 64'd1);
        fco_data = FRAME; @(negedge CLKDIV);
        check("recover_locked", 64'(locked), 64'd1);
        check("recover_err_cnt", 64'(frame_err_cnt), 64'd3);
        for (int j = 0; j < MISS_LIMIT; j++) begin
            fco_data = 8'(j + 1);
            @(negedge CLKDIV);
        end
        check("drop_locked", 64'(locked), 64'd0);
        check("drop_valid", 64'(sample_valid), 64'd0);
        check("drop_err_cnt", 64'(frame_err_cnt), 64'd7);
        check("drop_slip_cnt", 64'(slip_cnt), 64'd0);
        fco_data = FRAME;
        lock_at = 0;
        pulses  = 0;
        for (int i = 1; i <= 60 && lock_at == 0; i++) begin
            @(negedge CLKDIV);
            if (bitslip) pulses++;
            if (locked) lock_at = i;
        end
        check("relock_latency", 64'(lock_at), 64'(SLIP_WAIT + LOCK_COUNT));
        check("relock_no_slip", 64'(pulses), 64'd0);

        // Random lanes and random frame misses while locked.
        err_m    = 16'd7;
        run      = 0;
        exp_lock = 1'b1;
        for (int n = 0; n < 80; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r1 = 8'($urandom);
                r0 = 8'($urandom);
                lane1_data[c*SER_W +: SER_W] = r1;
                lane0_data[c*SER_W +: SER_W] = r0;
                pl1[c] = r1;
                pl0[c] = r0;
            end
            miss = ($urandom_range(2) == 0);
            fv   = 8'($urandom);
            if (fv == FRAME) fv = fv ^ 8'h01;
            fco_data = miss ? fv : FRAME;
            @(negedge CLKDIV);
            if (miss) begin
                if (err_m != 16'hFFFF) err_m = err_m + 16'd1;
                run++;
            end else begin
                run = 0;
            end
            if (run >= MISS_LIMIT) exp_lock = 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                check("rand_sample", 64'(sample_o[c*RES +: RES]), 64'(model_sample(32'(pl1[c]), 32'(pl0[c]))));
            check("rand_locked", 64'(locked), 64'(exp_lock));
            check("rand_valid", 64'(sample_valid), 64'(exp_lock));
            check("rand_err_cnt", 64'(frame_err_cnt), 64'(err_m));
            if (!exp_lock) break;
        end

        fco_data = FRAME;
        en = 1'b0;
        @(negedge CLKDIV);
        check("en_off_locked", 64'(locked), 64'd0);
        check("en_off_valid", 64'(sample_valid), 64'd0);
        check("en_off_err_held", 64'(frame_err_cnt), 64'(err_m));

        // Frame word three slips away; each pulse rotates it left by one.
        fv = FRAME;
        for (int j = 0; j < 3; j++) fv = {fv[0], fv[7:1]};
        fco_data  = fv;
        en        = 1'b1;
        pulses    = 0;
        last      = 0;
        width_bad = 0;
        prev_bs   = 1'b0;
        lock_at   = 0;
        gaps.delete();
        for (int i = 1; i <= 200 && lock_at == 0; i++) begin
            @(negedge CLKDIV);
            if (bitslip) begin
                if (prev_bs) width_bad++;
                if (pulses > 0) gaps.push_back(i - last);
                last = i;
                pulses++;
                fco_data = {fco_data[6:0], fco_data[7]};
            end
            prev_bs = bitslip;
            if (locked) lock_at = i;
        end
        check("rot_pulses", 64'(pulses), 64'd3);
        check("rot_width", 64'(width_bad), 64'd0);
        check("rot_gap_count", 64'(gaps.size()), 64'd2);
        foreach (gaps[g]) check("rot_gap", 64'(gaps[g]), 64'(SLIP_WAIT + 2));
        check("rot_slip_cnt", 64'(slip_cnt), 64'd3);
        check("rot_locked", 64'(locked), 64'd1);

        // Frame word never matches: exhaust the slip budget.
        en = 1'b0;
        @(negedge CLKDIV);
        fco_data = 8'hAA;
        en       = 1'b1;
        pulses   = 0;
        err_at   = 0;
        for (int i = 1; i <= 300 && err_at == 0; i++) begin
            @(negedge CLKDIV);
            if (bitslip) pulses++;
            if (align_err) err_at = i;
        end
        check("err_align_err", 64'(align_err), 64'd1);
        check("err_pulses", 64'(pulses), 64'(2*SER_W));
        check("err_slip_cnt", 64'(slip_cnt), 64'(2*SER_W));
        check("err_locked", 64'(locked), 64'd0);
        extra = 0;
        repeat (30) begin
            @(negedge CLKDIV);
            if (bitslip) extra++;
        end
        check("err_no_more_pulses", 64'(extra), 64'd0);
        check("err_sticky", 64'(align_err), 64'd1);
        en = 1'b0;
        @(negedge CLKDIV);
        check("err_clear", 64'(align_err), 64'd0);
        check("err_clear_slip_cnt", 64'(slip_cnt), 64'd0);
        check("err_clear_bitslip", 64'(bitslip), 64'd0);

        // Asynchronous reset in the middle of VERIFY.
        fco_data   = FRAME;
        lane0_data = {NUM_CH{8'h5A}};
        lane1_data = {NUM_CH{8'h3C}};
        en         = 1'b1;
        repeat (8) @(negedge CLKDIV);
        check("verify_not_locked", 64'(locked), 64'd0);
        check("verify_err_cnt", 64'(frame_err_cnt), 64'(err_m));
        #2 cpu_resetn = 1'b0;
        #1 check_all_zero("areset_verify");
        @(negedge CLKDIV);
        cpu_resetn = 1'b1;

        // Asynchronous reset while a bitslip pulse is high.
        fco_data = 8'hAA;
        prev_bs  = 1'b0;
        for (int i = 0; i < 20 && !prev_bs; i++) begin
            @(negedge CLKDIV);
            prev_bs = bitslip;
        end
        check("pulse_seen", 64'(prev_bs), 64'd1);
        #2 cpu_resetn = 1'b0;
        #1 check_all_zero("areset_slip");
        @(negedge CLKDIV);
        cpu_resetn = 1'b1;
        en = 1'b0;
        @(negedge CLKDIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
